// File: rtl/risc_v_pkg.sv
// Shared RV32I decode definitions: ALU operation codes, opcodes, operand
// select encodings and the decoded-bundle record passed to execute.
package risc_v_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SLL  = 5'b00001,
    ALU_SLTS = 5'b00010,
    ALU_SLTU = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SRL  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_AND  = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_SRA  = 5'b01101,
    ALU_EQ   = 5'b11000,
    ALU_NE   = 5'b11001,
    ALU_LTS  = 5'b11100,
    ALU_GES  = 5'b11101,
    ALU_LTU  = 5'b11110,
    ALU_GEU  = 5'b11111
  } alu_op_e;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_src_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef struct packed {
    alu_op_e     alu_op;
    a_sel_e      a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wb_en;
    wb_src_e     wb_src;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } dec_bundle_t;

  // Idle bundle: also the reset value of the buffer entries.
  function automatic dec_bundle_t dec_nop();
    dec_bundle_t b;
    b.alu_op   = ALU_ADD;
    b.a_sel    = A_RS1;
    b.b_sel    = 1'b0;
    b.imm      = '0;
    b.rs1      = '0;
    b.rs2      = '0;
    b.rd       = '0;
    b.wb_en    = 1'b0;
    b.wb_src   = WB_ALU;
    b.mem_req  = 1'b0;
    b.mem_we   = 1'b0;
    b.mem_size = '0;
    b.branch   = 1'b0;
    b.jal      = 1'b0;
    b.jalr     = 1'b0;
    b.illegal  = 1'b0;
    return b;
  endfunction

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLTS;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/risc_v_decoder.sv
// Combinational RV32I decoder: one instruction word in, one decoded bundle out.
// Register index fields are passed through raw; R-type and FENCE carry imm 0.
module risc_v_decoder
  import risc_v_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_bundle_t dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ill;
  dec_bundle_t d;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    d     = dec_nop();
    ill   = 1'b0;
    d.rs1 = instr_i[19:15];
    d.rs2 = instr_i[24:20];
    d.rd  = instr_i[11:7];
    case (opcode)
      OPC_OP: begin
        d.wb_en = 1'b1;
        case (f3)
          3'b000: begin
            if (f7 == 7'b0100000) d.alu_op = ALU_SUB;
            else                  ill      = (f7 != 7'b0000000);
          end
          3'b101: begin
            if (f7 == 7'b0100000) d.alu_op = ALU_SRA;
            else begin
              d.alu_op = ALU_SRL;
              ill      = (f7 != 7'b0000000);
            end
          end
          default: begin
            d.alu_op = alu_from_f3(f3);
            ill      = (f7 != 7'b0000000);
          end
        endcase
      end
      OPC_OP_IMM: begin
        d.wb_en  = 1'b1;
        d.b_sel  = 1'b1;
        d.imm    = imm_i;
        d.alu_op = alu_from_f3(f3);
        if (f3 == 3'b001) ill = (f7 != 7'b0000000);
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000) d.alu_op = ALU_SRA;
          else                  ill      = (f7 != 7'b0000000);
        end
      end
      OPC_LOAD: begin
        d.wb_en    = 1'b1;
        d.wb_src   = WB_LOAD;
        d.b_sel    = 1'b1;
        d.imm      = imm_i;
        d.mem_req  = 1'b1;
        d.mem_size = f3;
        ill        = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        d.b_sel    = 1'b1;
        d.imm      = imm_s;
        d.mem_req  = 1'b1;
        d.mem_we   = 1'b1;
        d.mem_size = f3;
        ill        = (f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        d.imm    = imm_b;
        d.branch = 1'b1;
        case (f3)
          3'b000:  d.alu_op = ALU_EQ;
          3'b001:  d.alu_op = ALU_NE;
          3'b100:  d.alu_op = ALU_LTS;
          3'b101:  d.alu_op = ALU_GES;
          3'b110:  d.alu_op = ALU_LTU;
          3'b111:  d.alu_op = ALU_GEU;
          default: ill      = 1'b1;
        endcase
      end
      OPC_LUI: begin
        d.wb_en = 1'b1;
        d.a_sel = A_ZERO;
        d.b_sel = 1'b1;
        d.imm   = imm_u;
      end
      OPC_AUIPC: begin
        d.wb_en = 1'b1;
        d.a_sel = A_PC;
        d.b_sel = 1'b1;
        d.imm   = imm_u;
      end
      OPC_JAL: begin
        d.wb_en  = 1'b1;
        d.wb_src = WB_PC4;
        d.a_sel  = A_PC;
        d.b_sel  = 1'b1;
        d.imm    = imm_j;
        d.jal    = 1'b1;
      end
      OPC_JALR: begin
        d.wb_en  = 1'b1;
        d.wb_src = WB_PC4;
        d.b_sel  = 1'b1;
        d.imm    = imm_i;
        d.jalr   = 1'b1;
        ill      = (f3 != 3'b000);
      end
      OPC_MISC_MEM: ;
      default: ill = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) ill = 1'b1;

    // Illegal entries keep raw fields and imm but carry no side effects.
    if (ill) begin
      d.alu_op   = ALU_ADD;
      d.a_sel    = A_RS1;
      d.b_sel    = 1'b0;
      d.wb_en    = 1'b0;
      d.wb_src   = WB_ALU;
      d.mem_req  = 1'b0;
      d.mem_we   = 1'b0;
      d.mem_size = '0;
      d.branch   = 1'b0;
      d.jal      = 1'b0;
      d.jalr     = 1'b0;
      d.illegal  = 1'b1;
    end else if (d.rd == 5'd0) begin
      d.wb_en = 1'b0;
    end
  end

  assign dec_o = d;

endmodule

// File: rtl/risc_v_decode_stage.sv
// RV32I decode stage: combinational decoder feeding a 2-entry skid buffer so
// that instr_ready_o is registered while throughput stays at one beat/cycle.
//
// state    | meaning
// ST_EMPTY | no entries, dec_valid_o low
// ST_ONE   | head valid, can still accept
// ST_TWO   | head and skid valid, instr_ready_o low
module risc_v_decode_stage
  import risc_v_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [4:0]      alu_op_o,
  output logic [1:0]      a_sel_o,
  output logic            b_sel_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            wb_en_o,
  output logic [1:0]      wb_src_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [2:0]      mem_size_o,
  output logic            branch_o,
  output logic            jal_o,
  output logic            jalr_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] pc_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  dec_bundle_t     dec;
  dec_bundle_t     head_q, head_d, skid_q, skid_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
  logic [1:0]      state_q, state_d;
  logic            ready_q, ready_d;
  logic            accept, pop;

  risc_v_decoder u_decoder (
    .instr_i (instr_i),
    .dec_o   (dec)
  );

  assign accept = instr_valid_i & ready_q & ~flush_i;
  assign pop    = dec_valid_o & dec_ready_i & ~flush_i;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    head_pc_d = head_pc_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d    = dec;
          head_pc_d = pc_i;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          head_d    = dec;
          head_pc_d = pc_i;
        end else if (accept) begin
          skid_d    = dec;
          skid_pc_d = pc_i;
          state_d   = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d    = skid_q;
          head_pc_d = skid_pc_q;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= ST_EMPTY;
      ready_q   <= 1'b1;
      head_q    <= dec_nop();
      skid_q    <= dec_nop();
      head_pc_q <= RESET_PC;
      skid_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      head_pc_q <= head_pc_d;
      skid_pc_q <= skid_pc_d;
    end
  end

  assign instr_ready_o = ready_q;
  assign dec_valid_o   = (state_q != ST_EMPTY);
  assign alu_op_o      = head_q.alu_op;
  assign a_sel_o       = head_q.a_sel;
  assign b_sel_o       = head_q.b_sel;
  assign imm_o         = head_q.imm;
  assign rs1_o         = head_q.rs1;
  assign rs2_o         = head_q.rs2;
  assign rd_o          = head_q.rd;
  assign wb_en_o       = head_q.wb_en;
  assign wb_src_o      = head_q.wb_src;
  assign mem_req_o     = head_q.mem_req;
  assign mem_we_o      = head_q.mem_we;
  assign mem_size_o    = head_q.mem_size;
  assign branch_o      = head_q.branch;
  assign jal_o         = head_q.jal;
  assign jalr_o        = head_q.jalr;
  assign illegal_o     = head_q.illegal;
  assign pc_o          = head_pc_q;

endmodule

// File: tb/tb_risc_v_decode_stage.sv
// Testbench for risc_v_decode_stage: table of decode vectors through a
// scoreboard, plus backpressure, flush and asynchronous reset sequences.
module tb_risc_v_decode_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int NV = 21;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [4:0]  alu_op_o;
  logic [1:0]  a_sel_o;
  logic        b_sel_o;
  logic [31:0] imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        wb_en_o;
  logic [1:0]  wb_src_o;
  logic        mem_req_o, mem_we_o;
  logic [2:0]  mem_size_o;
  logic        branch_o, jal_o, jalr_o, illegal_o;
  logic [31:0] pc_o;

  risc_v_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .flush_i       (flush_i),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .alu_op_o      (alu_op_o),
    .a_sel_o       (a_sel_o),
    .b_sel_o       (b_sel_o),
    .imm_o         (imm_o),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o),
    .rd_o          (rd_o),
    .wb_en_o       (wb_en_o),
    .wb_src_o      (wb_src_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_size_o    (mem_size_o),
    .branch_o      (branch_o),
    .jal_o         (jal_o),
    .jalr_o        (jalr_o),
    .illegal_o     (illegal_o),
    .pc_o          (pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  alu;
    logic [1:0]  asel;
    logic        bsel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wbe;
    logic [1:0]  wbs;
    logic        mreq;
    logic        mwe;
    logic [2:0]  msz;
    logic        br;
    logic        jl;
    logic        jlr;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   n_pop = 0;
  int   p0;
  exp_t q[$];
  exp_t drv_exp;
  exp_t mon_e, mon_a, cur;
  vec_t vecs[NV];

  function automatic exp_t mk(input logic [4:0] alu, input logic [1:0] asel, input logic bsel,
                              input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic wbe, input logic [1:0] wbs,
                              input logic mreq, input logic mwe, input logic [2:0] msz,
                              input logic br, input logic jl, input logic jlr, input logic ill);
    exp_t e;
    e = '{alu, asel, bsel, imm, rs1, rs2, rd, wbe, wbs, mreq, mwe, msz, br, jl, jlr, ill, 32'h0};
    return e;
  endfunction

  function automatic exp_t act_bundle();
    exp_t a;
    a = {alu_op_o, a_sel_o, b_sel_o, imm_o, rs1_o, rs2_o, rd_o, wb_en_o, wb_src_o,
         mem_req_o, mem_we_o, mem_size_o, branch_o, jal_o, jalr_o, illegal_o, pc_o};
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] ins, input exp_t e);
    logic acc;
    logic done;
    done          = 1'b0;
    instr_i       = ins;
    pc_i          = e.pc;
    drv_exp       = e;
    instr_valid_i = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk_i);
      acc = instr_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) done = 1'b1;
    end
    chk("send_accept", {63'b0, done}, 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && q.size() != 0; t++) begin
      @(posedge clk_i);
      #1;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic exp_t with_pc(input exp_t e, input logic [31:0] pc);
    exp_t r;
    r    = e;
    r.pc = pc;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                          alu     as  b  imm           rs1 rs2 rd wbe wbs mr mw sz br j jr il
    vecs[0]  = '{32'h002081B3, mk(5'h00, 0, 0, 32'h0,        1,  2,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{32'hFFF00093, mk(5'h00, 0, 1, 32'hFFFFFFFF, 0, 31,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{32'h00208463, mk(5'h18, 0, 0, 32'h8,        1,  2,  8, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    vecs[3]  = '{32'h00000000, mk(5'h00, 0, 0, 32'h0,        0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[4]  = '{32'h40209093, mk(5'h00, 0, 0, 32'h402,      1,  2,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[5]  = '{32'h407302B3, mk(5'h08, 0, 0, 32'h0,        6,  7,  5, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[6]  = '{32'hFFC12203, mk(5'h00, 0, 1, 32'hFFFFFFFC, 2, 28,  4, 1, 1, 1, 0, 2, 0, 0, 0, 0)};
    vecs[7]  = '{32'h0050A623, mk(5'h00, 0, 1, 32'hC,        1,  5, 12, 0, 0, 1, 1, 2, 0, 0, 0, 0)};
    vecs[8]  = '{32'h123453B7, mk(5'h00, 2, 1, 32'h12345000, 8,  3,  7, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{32'hFFFFF417, mk(5'h00, 1, 1, 32'hFFFFF000, 31, 31, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{32'h010000EF, mk(5'h00, 1, 1, 32'h10,       0, 16,  1, 1, 2, 0, 0, 0, 0, 1, 0, 0)};
    vecs[11] = '{32'h00008067, mk(5'h00, 0, 1, 32'h0,        1,  0,  0, 0, 2, 0, 0, 0, 0, 0, 1, 0)};
    vecs[12] = '{32'hFE41EEE3, mk(5'h1E, 0, 0, 32'hFFFFFFFC, 3,  4, 29, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    vecs[13] = '{32'h00002063, mk(5'h00, 0, 0, 32'h0,        0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[14] = '{32'h40315093, mk(5'h0D, 0, 1, 32'h403,      2,  3,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[15] = '{32'h00000073, mk(5'h00, 0, 0, 32'h0,        0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[16] = '{32'h0FF0000F, mk(5'h00, 0, 0, 32'h0,        0, 31,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[17] = '{32'h00003003, mk(5'h00, 0, 0, 32'h0,        0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[18] = '{32'h00000013, mk(5'h00, 0, 1, 32'h0,        0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[19] = '{32'h0220E1B3, mk(5'h00, 0, 0, 32'h0,        1,  2,  3, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[20] = '{32'h00003023, mk(5'h00, 0, 0, 32'h0,        0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};

    // Scoreboard monitor: pop and compare on every handshake, push on every accept.
    fork
      forever begin
        @(negedge clk_i);
        if (!arstn_i || flush_i) begin
          q.delete();
        end else begin
          if (dec_valid_o && dec_ready_i) begin
            checks++;
            n_pop++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_output actual_pc=%0h required=none", pc_o);
            end else begin
              mon_e = q.pop_front();
              mon_a = act_bundle();
              if (mon_a !== mon_e)
                begin
                  errors++;
                  $display("FAIL bundle pc=%0h actual=%h required=%h", mon_e.pc, mon_a, mon_e);
                end
            end
          end
          if (instr_valid_i && instr_ready_o) q.push_back(drv_exp);
        end
      end
    join_none

    #1 arstn_i = 1'b0;
    #1;
    chk("rst_dec_valid", dec_valid_o, 0);
    chk("rst_instr_ready", instr_ready_o, 1);
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_alu_op", alu_op_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_ctrl", {wb_en_o, mem_req_o, branch_o, jal_o, jalr_o, illegal_o, rd_o}, 0);
    @(posedge clk_i);
    #3 arstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    p0 = n_pop;
    dec_ready_i = 1'b1;
    for (int i = 0; i < NV; i++) send(vecs[i].instr, with_pc(vecs[i].e, 32'h100 + 32'(i) * 4));
    instr_valid_i = 1'b0;
    drain();
    chk("table_pops", n_pop - p0, NV);

    // Backpressure: four beats, execute stalled for three cycles.
    p0 = n_pop;
    cur = vecs[1].e;
    dec_ready_i   = 1'b0;
    instr_i       = vecs[1].instr;
    instr_valid_i = 1'b1;
    pc_i = 32'h0; drv_exp = with_pc(cur, 32'h0);
    @(posedge clk_i); #1;
    pc_i = 32'h4; drv_exp = with_pc(cur, 32'h4);
    @(posedge clk_i); #1;
    chk("bp_ready_drop", instr_ready_o, 0);
    chk("bp_valid", dec_valid_o, 1);
    chk("bp_head_pc", pc_o, 0);
    pc_i = 32'h8; drv_exp = with_pc(cur, 32'h8);
    @(posedge clk_i); #1;
    chk("bp_ready_hold", instr_ready_o, 0);
    chk("bp_head_stable", pc_o, 0);
    dec_ready_i = 1'b1;
    send(vecs[1].instr, with_pc(cur, 32'h8));
    send(vecs[1].instr, with_pc(cur, 32'hC));
    instr_valid_i = 1'b0;
    drain();
    chk("bp_pops", n_pop - p0, 4);

    // Flush while full: nothing buffered or in flight may emerge.
    p0 = n_pop;
    dec_ready_i = 1'b0;
    send(vecs[0].instr, with_pc(vecs[0].e, 32'h40));
    send(vecs[0].instr, with_pc(vecs[0].e, 32'h44));
    chk("fl_full", instr_ready_o, 0);
    pc_i = 32'h48; drv_exp = with_pc(vecs[0].e, 32'h48);
    instr_valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    instr_valid_i = 1'b0;
    chk("fl_valid", dec_valid_o, 0);
    chk("fl_ready", instr_ready_o, 1);
    dec_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    chk("fl_no_pops", n_pop - p0, 0);
    send(vecs[2].instr, with_pc(vecs[2].e, 32'h50));
    instr_valid_i = 1'b0;
    drain();
    chk("fl_after_pops", n_pop - p0, 1);

    // Asynchronous reset mid-transfer with both entries occupied.
    p0 = n_pop;
    dec_ready_i = 1'b0;
    send(vecs[6].instr, with_pc(vecs[6].e, 32'h60));
    send(vecs[7].instr, with_pc(vecs[7].e, 32'h64));
    pc_i = 32'h68; drv_exp = with_pc(vecs[6].e, 32'h68);
    #2 arstn_i = 1'b0;
    #1;
    chk("ar_dec_valid", dec_valid_o, 0);
    chk("ar_instr_ready", instr_ready_o, 1);
    chk("ar_pc", pc_o, RST_PC);
    chk("ar_fields", {alu_op_o, imm_o, mem_req_o, mem_we_o, mem_size_o, wb_en_o}, 0);
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    dec_ready_i   = 1'b1;
    @(posedge clk_i);
    #3 arstn_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("ar_no_pops", n_pop - p0, 0);
    send(vecs[12].instr, with_pc(vecs[12].e, 32'h70));
    instr_valid_i = 1'b0;
    drain();
    chk("ar_after_pops", n_pop - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
